// File: rtl/conv_window_gen.sv
// Raster-scan 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// valid/ready on both the pixel input and the window output.
module conv_window_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win0,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              frame_last
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] win [9];
    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              emit;

    // Full-throughput handshake: a held window blocks new pixels, a consumed one does not.
    assign pix_ready = !rst && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col == COL_W'(IMG_W - 1));
    assign row_last  = (row == ROW_W'(IMG_H - 1));
    assign emit      = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // Line buffers are never reset; stale data only lands in rows that are not emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_last <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else begin
            if (accept) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb1[col];
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb0[col];
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pix_in;

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end

                win_valid  <= emit;
                frame_last <= emit && row_last && col_last;
            end else if (win_ready) begin
                win_valid  <= 1'b0;
                frame_last <= 1'b0;
            end
        end
    end

    assign win0 = win[0];
    assign win1 = win[1];
    assign win2 = win[2];
    assign win3 = win[3];
    assign win4 = win[4];
    assign win5 = win[5];
    assign win6 = win[6];
    assign win7 = win[7];
    assign win8 = win[8];

endmodule
